// File: rtl/seq_mult_pkg.sv
// Shared types and codes for the sequential 8x8 multiplier controller.
// The controller builds the product from four 4x4 partial products.
package seq_mult_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LSB  = 3'd1,
    ST_MID  = 3'd2,
    ST_MSB  = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } state_e;

  localparam logic [1:0] SHIFT_0 = 2'b00;
  localparam logic [1:0] SHIFT_4 = 2'b01;
  localparam logic [1:0] SHIFT_8 = 2'b10;

  // bit1 picks the high nibble of A, bit0 picks the high nibble of B
  localparam logic [1:0] SEL_AL_BL = 2'b00;
  localparam logic [1:0] SEL_AL_BH = 2'b01;
  localparam logic [1:0] SEL_AH_BL = 2'b10;
  localparam logic [1:0] SEL_AH_BH = 2'b11;

  function automatic logic is_busy(input state_e s);
    return (s == ST_LSB) || (s == ST_MID) || (s == ST_MSB);
  endfunction

endpackage

// File: rtl/seq_mult_ctrl_if.sv
// Control bundle between the multiplier sequencer and its datapath/host.
interface seq_mult_ctrl_if;
  logic       start;
  logic [1:0] input_sel;
  logic [1:0] shift_sel;
  logic       clk_ena;
  logic       sclr_n;
  logic       busy;
  logic       done;
  logic [2:0] state_out;

  modport master (
    output start,
    input  input_sel, shift_sel, clk_ena, sclr_n, busy, done, state_out
  );

  modport slave (
    input  start,
    output input_sel, shift_sel, clk_ena, sclr_n, busy, done, state_out
  );
endinterface

// File: rtl/seq_mult_ctrl_cycle_cnt.sv
// One-bit cycle counter for the two-cycle MID phase; saturates at 1.
module mult_cycle_cnt (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic count
);

  logic count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr)
      count_d = 1'b0;
    else if (en)
      count_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      count_q <= 1'b0;
    else
      count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/seq_mult_ctrl.sv
// Moore sequencer for an 8x8 multiply built from four 4x4 partial products.
//   state | meaning
//   IDLE  | waiting for the first start
//   LSB   | A.lo*B.lo loaded into the accumulator
//   MID   | two cycles: A.lo*B.hi then A.hi*B.lo, both shifted by 4
//   MSB   | A.hi*B.hi shifted by 8
//   DONE  | product register valid
//   ERR   | multiply aborted by start arriving mid-sequence
module seq_mult_ctrl
  import seq_mult_pkg::*;
(
  input  logic            clk,
  input  logic            reset_n,
  seq_mult_ctrl_if.slave  bus
);

  state_e state_q, state_d;
  logic   mid_cnt;
  logic   cnt_clr, cnt_en;

  // Holding the counter clear outside MID guarantees it starts at 0 on every entry.
  assign cnt_clr = (state_q != ST_MID);
  assign cnt_en  = (state_q == ST_MID);

  mult_cycle_cnt u_cycle_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .count   (mid_cnt)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.start) state_d = ST_LSB;
      ST_LSB:  state_d = bus.start ? ST_ERR : ST_MID;
      ST_MID: begin
        if (bus.start)
          state_d = ST_ERR;
        else if (mid_cnt)
          state_d = ST_MSB;
      end
      ST_MSB:  state_d = bus.start ? ST_ERR : ST_DONE;
      ST_DONE,
      ST_ERR:  if (bus.start) state_d = ST_LSB;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs depend only on registered state and counter, never on start.
  always_comb begin
    bus.input_sel = SEL_AL_BL;
    bus.shift_sel = SHIFT_0;
    bus.clk_ena   = 1'b0;
    bus.sclr_n    = 1'b1;
    case (state_q)
      ST_LSB: begin
        bus.clk_ena = 1'b1;
        bus.sclr_n  = 1'b0;
      end
      ST_MID: begin
        bus.input_sel = mid_cnt ? SEL_AH_BL : SEL_AL_BH;
        bus.shift_sel = SHIFT_4;
        bus.clk_ena   = 1'b1;
      end
      ST_MSB: begin
        bus.input_sel = SEL_AH_BH;
        bus.shift_sel = SHIFT_8;
        bus.clk_ena   = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.busy      = is_busy(state_q);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.state_out = state_q;

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Bench for seq_mult_ctrl: directed steps plus random start traffic, with a
// 4x4 datapath in the loop and a step-index reference model.
module tb_seq_mult_ctrl;
  import seq_mult_pkg::*;

  logic clk;
  logic reset_n;
  int   total;
  int   bad;

  seq_mult_ctrl_if bus();

  seq_mult_ctrl dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // datapath: 4x4 multiplier, shifter and accumulating product register
  logic [7:0]  op_a, op_b;
  logic [3:0]  na, nb;
  logic [15:0] pp, acc;

  always_comb begin
    na = bus.input_sel[1] ? op_a[7:4] : op_a[3:0];
    nb = bus.input_sel[0] ? op_b[7:4] : op_b[3:0];
    pp = 16'(na) * 16'(nb);
    if (bus.shift_sel == 2'b01)
      pp = pp << 4;
    else if (bus.shift_sel == 2'b10)
      pp = pp << 8;
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      acc <= 16'h0000;
    else if (bus.clk_ena)
      acc <= bus.sclr_n ? acc + pp : pp;
  end

  // reference model: a multiply is four numbered steps
  typedef enum {M_IDLE, M_RUN, M_DONE, M_ERR} mkind_e;
  mkind_e      mk;
  int          mstep;
  int          ena_seen;
  logic        just_done;
  logic [15:0] exp_prod;

  int run_st   [4] = '{1, 2, 2, 3};
  int run_isel [4] = '{0, 1, 2, 3};
  int run_ssel [4] = '{0, 1, 1, 2};
  int run_sclr [4] = '{0, 1, 1, 1};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic s);
    just_done = 1'b0;
    if (mk == M_RUN) begin
      if (s)
        mk = M_ERR;
      else if (mstep == 3) begin
        mk = M_DONE;
        just_done = 1'b1;
      end else
        mstep++;
    end else if (s) begin
      mk       = M_RUN;
      mstep    = 0;
      ena_seen = 0;
      exp_prod = 16'(op_a) * 16'(op_b);
    end
  endtask

  task automatic check_all();
    int e_st, e_is, e_ss, e_en, e_sc;
    e_is = 0; e_ss = 0; e_en = 0; e_sc = 1;
    case (mk)
      M_RUN: begin
        e_st = run_st[mstep];
        e_is = run_isel[mstep];
        e_ss = run_ssel[mstep];
        e_en = 1;
        e_sc = run_sclr[mstep];
      end
      M_DONE:  e_st = 4;
      M_ERR:   e_st = 5;
      default: e_st = 0;
    endcase
    chk("state_out", 32'(bus.state_out), 32'(e_st));
    chk("input_sel", 32'(bus.input_sel), 32'(e_is));
    chk("shift_sel", 32'(bus.shift_sel), 32'(e_ss));
    chk("clk_ena",   32'(bus.clk_ena),   32'(e_en));
    chk("sclr_n",    32'(bus.sclr_n),    32'(e_sc));
    chk("busy",      32'(bus.busy),      (mk == M_RUN)  ? 32'd1 : 32'd0);
    chk("done",      32'(bus.done),      (mk == M_DONE) ? 32'd1 : 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_state"}, 32'(bus.state_out), 32'd0);
    chk({tag, "_isel"},  32'(bus.input_sel), 32'd0);
    chk({tag, "_ssel"},  32'(bus.shift_sel), 32'd0);
    chk({tag, "_ena"},   32'(bus.clk_ena),   32'd0);
    chk({tag, "_sclr"},  32'(bus.sclr_n),    32'd1);
    chk({tag, "_busy"},  32'(bus.busy),      32'd0);
    chk({tag, "_done"},  32'(bus.done),      32'd0);
  endtask

  task automatic cycle(input logic s);
    bus.start = s;
    @(posedge clk);
    model_step(s);
    #1;
    if (bus.clk_ena === 1'b1)
      ena_seen++;
    check_all();
    if (just_done) begin
      chk("product",   32'(acc), 32'(exp_prod));
      chk("ena_count", 32'(ena_seen), 32'd4);
    end
  endtask

  initial begin
    logic s;
    total = 0; bad = 0;
    reset_n = 1'b0; bus.start = 1'b0;
    op_a = 8'h00; op_b = 8'h00;
    mk = M_IDLE; mstep = 0; ena_seen = 0; just_done = 1'b0; exp_prod = 16'h0;

    #2 check_reset_outputs("por");
    @(posedge clk); #1 reset_n = 1'b1;
    cycle(0); cycle(0);

    // single start pulse: 1,2,2,3,4 then hold 4
    op_a = 8'h12; op_b = 8'h34;
    cycle(1); chk("seq_t1", 32'(bus.state_out), 32'd1);
    chk("seq_t1_sclr", 32'(bus.sclr_n), 32'd0);
    cycle(0); chk("seq_t2", 32'(bus.state_out), 32'd2);
    cycle(0); chk("seq_t3", 32'(bus.state_out), 32'd2);
    chk("seq_t3_isel", 32'(bus.input_sel), 32'd2);
    cycle(0); chk("seq_t4", 32'(bus.state_out), 32'd3);
    cycle(0); chk("seq_t5", 32'(bus.state_out), 32'd4);
    cycle(0); chk("seq_hold", 32'(bus.state_out), 32'd4);
    chk("prod_1234", 32'(acc), 32'h03A8);

    op_a = 8'hFF; op_b = 8'hFF;
    cycle(1); repeat (4) cycle(0);
    chk("prod_ffff", 32'(acc), 32'hFE01);
    chk("prod_ffff_done", 32'(bus.done), 32'd1);

    op_a = 8'h00; op_b = 8'hAB;
    cycle(1); repeat (4) cycle(0);
    chk("prod_00ab", 32'(acc), 32'h0000);

    // abort in the second MID cycle, then a clean run
    op_a = 8'h5A; op_b = 8'hC3;
    cycle(1); cycle(0); cycle(0); cycle(1);
    chk("abort_state", 32'(bus.state_out), 32'd5);
    chk("abort_busy",  32'(bus.busy), 32'd0);
    chk("abort_ena",   32'(bus.clk_ena), 32'd0);
    cycle(0);
    cycle(1); repeat (4) cycle(0);
    chk("after_abort", 32'(acc), 32'(16'h5A * 16'hC3));

    // asynchronous reset while in MSB
    cycle(1); cycle(0); cycle(0); cycle(0);
    chk("msb_reached", 32'(bus.state_out), 32'd3);
    #2 reset_n = 1'b0;
    mk = M_IDLE;
    #1 check_reset_outputs("async_rst");
    @(posedge clk); #1 check_reset_outputs("rst_held");
    reset_n = 1'b1;
    cycle(0); cycle(0);

    // start held high: LSB/ERR alternation
    cycle(1); chk("hold_lsb1", 32'(bus.state_out), 32'd1);
    cycle(1); chk("hold_err1", 32'(bus.state_out), 32'd5);
    cycle(1); chk("hold_lsb2", 32'(bus.state_out), 32'd1);
    cycle(1); chk("hold_err2", 32'(bus.state_out), 32'd5);
    cycle(0);

    // back-to-back with start high for exactly the DONE cycle
    op_a = 8'h9C; op_b = 8'h47;
    cycle(1); repeat (4) cycle(0);
    op_a = 8'h3E; op_b = 8'hD1;
    cycle(1); chk("b2b_restart", 32'(bus.state_out), 32'd1);
    repeat (4) cycle(0);

    // random start traffic
    for (int i = 0; i < 400; i++) begin
      s = ($urandom_range(0, 99) < 20);
      if (s && mk != M_RUN) begin
        op_a = 8'($urandom);
        op_b = 8'($urandom);
      end
      cycle(s);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_mult_ctrl.md
SEQ_MULT_CTRL -- requirements
Module: seq_mult_ctrl

Interface
REQ-001: clk  input  1  single clock; all state changes on rising edge.
REQ-002: reset_n  input  1  asynchronous, active-low reset.
REQ-003: start  input  1  request to begin one 8x8 multiply; sampled every cycle.
REQ-004: input_sel  output  2  nibble select for the 4x4 multiplier: bit1 = operand A high nibble, bit0 = operand B high nibble.
REQ-005: shift_sel  output  2  shifter control: 00 = no shift, 01 = shift left 4, 10 = shift left 8; 11 is never driven.
REQ-006: clk_ena  output  1  product-register enable.
REQ-007: sclr_n  output  1  active-low: accumulator loads the partial product instead of adding it.
REQ-008: busy  output  1  a multiply is in progress.
REQ-009: done  output  1  the product register holds a valid result.
REQ-010: state_out  output  3  current state code, for debug and display.

Function
REQ-011: The block SHALL implement a Moore FSM with six states: IDLE=0, LSB=1, MID=2, MSB=3, DONE=4, ERR=5; state_out = state code.
REQ-012: IDLE SHALL go to LSB when start=1, else stay in IDLE.
REQ-013: LSB SHALL go to MID after one cycle when start=0.
REQ-014: MID SHALL last exactly two cycles, tracked by an internal 1-bit cycle counter (count 0 then 1), then go to MSB when start=0.
REQ-015: MSB SHALL go to DONE after one cycle when start=0.
REQ-016: start=1 in LSB, MID or MSB SHALL abort the multiply and move to ERR on the next edge, taking priority over normal progression.
REQ-017: DONE and ERR SHALL go to LSB when start=1, else hold.
REQ-018: Per-state outputs SHALL be:
- LSB: input_sel=00, shift_sel=00, clk_ena=1, sclr_n=0.
- MID count 0: input_sel=01, shift_sel=01, clk_ena=1, sclr_n=1.
- MID count 1: input_sel=10, shift_sel=01, clk_ena=1, sclr_n=1.
- MSB: input_sel=11, shift_sel=10, clk_ena=1, sclr_n=1.
- IDLE, DONE, ERR: input_sel=00, shift_sel=00, clk_ena=0, sclr_n=1.
REQ-019: busy SHALL be 1 exactly in LSB, MID and MSB; done SHALL be 1 exactly in DONE.
REQ-020: Outputs SHALL decode from registered state and counter only, with no combinational path from start.
REQ-021: Latency: start=1 sampled in cycle t from IDLE gives LSB at t+1, MID at t+2 and t+3, MSB at t+4, DONE at t+5; exactly four clk_ena cycles per multiply.
REQ-022: The MID counter SHALL clear on every entry to MID and SHALL not wrap beyond 1.
REQ-023: start held high across DONE SHALL start back-to-back multiplies; DONE is visible for one cycle between them.

Reset
REQ-024: reset_n=0 SHALL asynchronously force state=IDLE and counter=0 in any state, including mid-multiply.
REQ-025: While reset_n=0, outputs SHALL be: state_out=0, input_sel=00, shift_sel=00, clk_ena=0, sclr_n=1, busy=0, done=0.
REQ-026: The first transition after reset release SHALL occur on the first rising edge with reset_n=1.

Structure
REQ-027: A shared package seq_mult_pkg SHALL hold:
- the state enum and its codes;
- the shift_sel codes SHIFT_0, SHIFT_4, SHIFT_8;
- the input_sel nibble-select constants.
REQ-028: The FSM and output decode SHALL reside in seq_mult_ctrl; the MID cycle counter is the one natural sub-module, mult_cycle_cnt (clear and enable inputs, 1-bit count).

Verification
REQ-029: Reset, then a 1-cycle start pulse -> state_out sequence 1,2,2,3,4, then holds 4. Per-cycle (input_sel, shift_sel) = 00/00, 01/01, 10/01, 11/10. clk_ena high for exactly 4 cycles. sclr_n low only in the first of them.
REQ-030: Datapath-in-loop with A=0xFF, B=0xFF -> product 0xFE01 with done=1. A=0x00, B=0xAB -> 0x0000.
REQ-031: start reasserted in the second MID cycle -> state_out=5, busy=0, clk_ena=0 next cycle. A later start pulse -> full normal sequence.
REQ-032: reset_n dropped asynchronously during MSB -> all outputs at reset values before the next clk edge. After release with start=0 -> remains IDLE.
REQ-033: start held high continuously from IDLE -> the first LSB cycle then ERR, after which the FSM alternates LSB/ERR; a single start pulse in DONE -> a clean restart.
